line_buffer_4row: RTL

Raster-scan row buffer that feeds the disparity window stage. It accepts one pixel per clken beat, stores the three previous image rows in on-chip line memories, and presents four vertically aligned pixels (rows r-3..r, same column) on linebuffer0..linebuffer3. The window shift registers downstream are driven directly from these four outputs and share the same clken.

---
 rtl/line_buffer_4row.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/line_buffer_4row.sv
// line_buffer_4row
//
// Raster-scan row buffer for the disparity window stage. Each clken beat
// accepts one pixel, stores it in a chain of three line memories and
// presents four vertically aligned pixels (rows r-3..r, same column) one
// beat later.
//
// Ports
//   clock        system clock, rising edge
//   rst          asynchronous, active-low reset
//   clken        pixel-valid strobe; nothing advances while low
//   width        active line length, sampled on clken & frame_start
//   frame_start  marks the pixel at row 0, column 0 (qualified by clken)
//   pixel_in     incoming raster pixel
//   linebuffer0  row r-3 (oldest)
//   linebuffer1  row r-2
//   linebuffer2  row r-1
//   linebuffer3  row r (current pixel, registered)
//   out_valid    all four outputs carry real rows of the current frame
//   col_last     outputs belong to column width_q-1
//
// Build option
//   LB_REPLICATE_EN  when defined, rows not yet filled in this frame
//                    replicate the oldest valid row (top-border extension)
//                    instead of reading as zero.

module line_buffer_4row #(
    parameter int PIXEL_WIDTH = 8,
    parameter int MAX_WIDTH   = 2047,
    parameter int ADDR_WIDTH  = 11
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   clken,
    input  logic [ADDR_WIDTH-1:0]  width,
    input  logic                   frame_start,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    output logic [PIXEL_WIDTH-1:0] linebuffer0,
    output logic [PIXEL_WIDTH-1:0] linebuffer1,
    output logic [PIXEL_WIDTH-1:0] linebuffer2,
    output logic [PIXEL_WIDTH-1:0] linebuffer3,
    output logic                   out_valid,
    output logic                   col_last
);

    localparam logic [ADDR_WIDTH-1:0] MAX_W = ADDR_WIDTH'(MAX_WIDTH);

    // Line memories: m0 holds row r-1, m1 row r-2, m2 row r-3.
    logic [PIXEL_WIDTH-1:0] m0 [MAX_WIDTH];
    logic [PIXEL_WIDTH-1:0] m1 [MAX_WIDTH];
    logic [PIXEL_WIDTH-1:0] m2 [MAX_WIDTH];

    logic [ADDR_WIDTH-1:0]  col_q, col_d;
    logic [1:0]             row_q, row_d;
    logic [ADDR_WIDTH-1:0]  width_q, width_d;
    logic [PIXEL_WIDTH-1:0] lb0_q, lb0_d;
    logic [PIXEL_WIDTH-1:0] lb1_q, lb1_d;
    logic [PIXEL_WIDTH-1:0] lb2_q, lb2_d;
    logic [PIXEL_WIDTH-1:0] lb3_q, lb3_d;
    logic                   valid_q, valid_d;
    logic                   col_last_q, col_last_d;

    logic [31:0]            width_ext;
    logic [ADDR_WIDTH-1:0]  width_sel;
    logic [ADDR_WIDTH-1:0]  width_eff;
    logic [ADDR_WIDTH-1:0]  col_eff;
    logic [1:0]             row_eff;
    logic                   is_last;
    logic [PIXEL_WIDTH-1:0] rd0, rd1, rd2;

    // frame_start relabels the current pixel as (0,0) and brings in the new
    // width on the same beat, so that pixel already uses the new geometry.
    always_comb begin
        width_ext = 32'(width);
        width_sel = width;
        if ((width == '0) || (width_ext > 32'(MAX_WIDTH))) begin
            width_sel = MAX_W;
        end
        width_eff = frame_start ? width_sel : width_q;
        col_eff   = frame_start ? '0 : col_q;
        row_eff   = frame_start ? 2'd0 : row_q;
        is_last   = (col_eff == (width_eff - ADDR_WIDTH'(1)));
        rd0       = m0[col_eff];
        rd1       = m1[col_eff];
        rd2       = m2[col_eff];
    end

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        width_d    = width_q;
        lb0_d      = lb0_q;
        lb1_d      = lb1_q;
        lb2_d      = lb2_q;
        lb3_d      = lb3_q;
        valid_d    = valid_q;
        col_last_d = col_last_q;
        if (clken) begin
            width_d = width_eff;
            if (is_last) begin
                col_d = '0;
                row_d = (row_eff == 2'd3) ? 2'd3 : row_eff + 2'd1;
            end else begin
                col_d = col_eff + ADDR_WIDTH'(1);
                row_d = row_eff;
            end
            lb3_d = pixel_in;
`ifdef LB_REPLICATE_EN
            // Each unfilled row falls back to the oldest row written so far.
            case (row_eff)
                2'd0: begin
                    lb2_d = pixel_in;
                    lb1_d = pixel_in;
                    lb0_d = pixel_in;
                end
                2'd1: begin
                    lb2_d = rd0;
                    lb1_d = rd0;
                    lb0_d = rd0;
                end
                2'd2: begin
                    lb2_d = rd0;
                    lb1_d = rd1;
                    lb0_d = rd1;
                end
                default: begin
                    lb2_d = rd0;
                    lb1_d = rd1;
                    lb0_d = rd2;
                end
            endcase
`else
            // Memory contents from an earlier frame are hidden until this
            // frame has overwritten the corresponding row.
            lb2_d = (row_eff >= 2'd1) ? rd0 : '0;
            lb1_d = (row_eff >= 2'd2) ? rd1 : '0;
            lb0_d = (row_eff == 2'd3) ? rd2 : '0;
`endif
            valid_d    = (row_eff == 2'd3);
            col_last_d = is_last;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            col_q      <= '0;
            row_q      <= 2'd0;
            width_q    <= MAX_W;
            lb0_q      <= '0;
            lb1_q      <= '0;
            lb2_q      <= '0;
            lb3_q      <= '0;
            valid_q    <= 1'b0;
            col_last_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            width_q    <= width_d;
            lb0_q      <= lb0_d;
            lb1_q      <= lb1_d;
            lb2_q      <= lb2_d;
            lb3_q      <= lb3_d;
            valid_q    <= valid_d;
            col_last_q <= col_last_d;
        end
    end

    // Read-before-write: rd* sample the old contents before this edge, so
    // each row shifts one memory deeper per beat at the same column.
    always_ff @(posedge clock) begin
        if (clken) begin
            m0[col_eff] <= pixel_in;
            m1[col_eff] <= rd0;
            m2[col_eff] <= rd1;
        end
    end

    assign linebuffer0 = lb0_q;
    assign linebuffer1 = lb1_q;
    assign linebuffer2 = lb2_q;
    assign linebuffer3 = lb3_q;
    assign out_valid   = valid_q;
    assign col_last    = col_last_q;

endmodule
